neuron_rr_sched: RTL and testbench

Round-robin job scheduler that shares one neuron compute unit (datapath plus its sequencing controller) among `R` requesters. It sits between the requesters and the neuron's controller. Per job it:
- selects one requester fairly;
- latches that requester's x/w base addresses and drives them to the neuron;
- pulses the neuron start;
- waits for neuron completion, aborting after a watchdog timeout;
- returns a completion/error pulse to the owning requester.

---
 rtl/neuron_sched_pkg.sv | 15 +
 rtl/rr_arbiter.sv | 32 +++
 rtl/neuron_rr_sched.sv | 128 ++++++++++++
 tb/tb_neuron_rr_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_sched_pkg.sv
// Shared types and default sizing for the round-robin neuron job scheduler.
package neuron_sched_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_RUN   = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam int DEF_R       = 4;
  localparam int DEF_Q       = 8;
  localparam int DEF_TIMEOUT = 1024;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request bit after `last`, wrapping modulo R.
module rr_arbiter #(
  parameter int R = 4
) (
  input  logic [R-1:0]         req,
  input  logic [$clog2(R)-1:0] last,
  output logic [R-1:0]         pick,
  output logic [$clog2(R)-1:0] idx
);

  localparam int LW = $clog2(R);

  logic [LW-1:0] w_j;
  logic          w_found;

  always_comb begin
    pick    = '0;
    idx     = '0;
    w_found = 1'b0;
    w_j     = '0;
    // Offsets 1..R visit every requester once, ending at `last` itself.
    for (int i = 1; i <= R; i++) begin
      w_j = LW'((int'(last) + i) % R);
      if (!w_found && req[w_j]) begin
        w_found   = 1'b1;
        pick[w_j] = 1'b1;
        idx       = w_j;
      end
    end
  end

endmodule

// File: rtl/neuron_rr_sched.sv
// Shares one neuron compute unit among R requesters: round-robin pick, base latch,
// start pulse, completion/watchdog wait, and an ack/err pulse back to the owner.
module neuron_rr_sched
  import neuron_sched_pkg::*;
#(
  parameter int R       = DEF_R,
  parameter int Q       = DEF_Q,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [R-1:0]         req,
  input  logic [R*Q-1:0]       base_x,
  input  logic [R*Q-1:0]       base_w,
  input  logic                 nrn_done,
  output logic [R-1:0]         gnt,
  output logic [R-1:0]         ack,
  output logic [R-1:0]         err,
  output logic                 nrn_st,
  output logic                 nrn_abort,
  output logic [Q-1:0]         nrn_base_x,
  output logic [Q-1:0]         nrn_base_w,
  output logic [$clog2(R)-1:0] owner,
  output logic                 busy
);

  localparam int            LW     = $clog2(R);
  localparam int            TW     = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [LW-1:0] r_owner;
  logic [LW-1:0] r_last;
  logic [R-1:0]  r_gnt;
  logic [R-1:0]  r_ack;
  logic [R-1:0]  r_err;
  logic          r_st;
  logic          r_abort;
  logic          r_busy;
  logic [Q-1:0]  r_bx;
  logic [Q-1:0]  r_bw;
  logic [TW-1:0] r_timer;

  logic [R-1:0]  w_pick;
  logic [LW-1:0] w_idx;
  logic [Q-1:0]  w_bx;
  logic [Q-1:0]  w_bw;

  rr_arbiter #(.R(R)) u_arb (
    .req  (req),
    .last (r_last),
    .pick (w_pick),
    .idx  (w_idx)
  );

  assign w_bx = base_x[int'(w_idx)*Q +: Q];
  assign w_bw = base_w[int'(w_idx)*Q +: Q];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_owner <= '0;
      r_last  <= LW'(R - 1);
      r_gnt   <= '0;
      r_ack   <= '0;
      r_err   <= '0;
      r_st    <= 1'b0;
      r_abort <= 1'b0;
      r_busy  <= 1'b0;
      r_bx    <= '0;
      r_bw    <= '0;
      r_timer <= '0;
    end else begin
      r_st    <= 1'b0;
      r_abort <= 1'b0;
      r_ack   <= '0;
      r_err   <= '0;
      case (r_state)
        S_IDLE: begin
          if (|req) begin
            r_state <= S_START;
            r_owner <= w_idx;
            r_gnt   <= w_pick;
            r_bx    <= w_bx;
            r_bw    <= w_bw;
            r_busy  <= 1'b1;
            r_st    <= 1'b1;
          end
        end
        S_START: begin
          r_timer <= '0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          r_timer <= r_timer + TW'(1);
          // A completion landing on the final watchdog cycle beats the abort.
          if (nrn_done) begin
            r_state <= S_RESP;
            r_ack   <= r_gnt;
          end else if (r_timer == T_LAST) begin
            r_state <= S_RESP;
            r_ack   <= r_gnt;
            r_err   <= r_gnt;
            r_abort <= 1'b1;
          end
        end
        S_RESP: begin
          r_last  <= r_owner;
          r_gnt   <= '0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign gnt        = r_gnt;
  assign ack        = r_ack;
  assign err        = r_err;
  assign nrn_st     = r_st;
  assign nrn_abort  = r_abort;
  assign nrn_base_x = r_bx;
  assign nrn_base_w = r_bw;
  assign owner      = r_owner;
  assign busy       = r_busy;

endmodule

// File: tb/tb_neuron_rr_sched.sv
// Table-driven bench for neuron_rr_sched with a job scoreboard and reset/spurious-input sequences.
module tb_neuron_rr_sched;

  localparam int R  = 4;
  localparam int Q  = 8;
  localparam int TO = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic [R-1:0] req;
  logic [R*Q-1:0] base_x, base_w;
  logic         nrn_done;
  logic [R-1:0] gnt, ack, err;
  logic         nrn_st, nrn_abort, busy;
  logic [Q-1:0] nrn_base_x, nrn_base_w;
  logic [1:0]   owner;

  neuron_rr_sched #(.R(R), .Q(Q), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .base_x     (base_x),
    .base_w     (base_w),
    .nrn_done   (nrn_done),
    .gnt        (gnt),
    .ack        (ack),
    .err        (err),
    .nrn_st     (nrn_st),
    .nrn_abort  (nrn_abort),
    .nrn_base_x (nrn_base_x),
    .nrn_base_w (nrn_base_w),
    .owner      (owner),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  rq;
    logic [31:0] bx;
    logic [31:0] bw;
    int          dly;    // done sampled at edge dly+1 after START; <0 means never
    bit          chg;    // drop req and scramble bases mid-RUN
    logic [3:0]  gnt_e;
    int          own_e;
    logic [7:0]  bx_e;
    logic [7:0]  bw_e;
    bit          err_e;
    int          ack_e;  // cycle index of ack, START cycle = 1
  } vec_t;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] bx;
    logic [7:0] bw;
    bit         err;
    int         ack_cyc;
  } exp_t;

  localparam logic [31:0] B_X = 32'h4433_2211;
  localparam logic [31:0] B_W = 32'hD4C3_B2A1;

  int   n_chk  = 0;
  int   n_fail = 0;
  vec_t tbl[10];
  exp_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] rq, input logic [31:0] bx, input logic [31:0] bw,
                              input int dly, input bit chg, input logic [3:0] g, input int o,
                              input logic [7:0] ex, input logic [7:0] ew, input bit e, input int a);
    vec_t v;
    v.rq = rq; v.bx = bx; v.bw = bw; v.dly = dly; v.chg = chg;
    v.gnt_e = g; v.own_e = o; v.bx_e = ex; v.bw_e = ew; v.err_e = e; v.ack_e = a;
    return v;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_gnt"},   32'(gnt),        32'd0);
    chk({tag, "_ack"},   32'(ack),        32'd0);
    chk({tag, "_err"},   32'(err),        32'd0);
    chk({tag, "_st"},    32'(nrn_st),     32'd0);
    chk({tag, "_abort"}, 32'(nrn_abort),  32'd0);
    chk({tag, "_busy"},  32'(busy),       32'd0);
    chk({tag, "_owner"}, 32'(owner),      32'd0);
    chk({tag, "_bx"},    32'(nrn_base_x), 32'd0);
    chk({tag, "_bw"},    32'(nrn_base_w), 32'd0);
  endtask

  // Entered and left on a negedge with the DUT in IDLE.
  task automatic run_vec(input vec_t v, input int id);
    exp_t e;
    bit   acked;
    int   aborts;
    int   wait_n;
    req      = v.rq;
    base_x   = v.bx;
    base_w   = v.bw;
    nrn_done = 1'b0;
    @(negedge clk);
    chk($sformatf("v%0d_st_latency", id), 32'(nrn_st), 32'd1);
    wait_n = 0;
    while (!nrn_st && wait_n < 8) begin
      @(negedge clk);
      wait_n++;
    end
    if (!nrn_st) begin
      chk($sformatf("v%0d_start_timeout", id), 32'(nrn_st), 32'd1);
      req = '0;
      return;
    end
    e.gnt = v.gnt_e; e.bx = v.bx_e; e.bw = v.bw_e; e.err = v.err_e; e.ack_cyc = v.ack_e;
    sb.push_back(e);
    chk($sformatf("v%0d_gnt", id),   32'(gnt),        32'(v.gnt_e));
    chk($sformatf("v%0d_owner", id), 32'(owner),      32'(v.own_e));
    chk($sformatf("v%0d_bx", id),    32'(nrn_base_x), 32'(v.bx_e));
    chk($sformatf("v%0d_bw", id),    32'(nrn_base_w), 32'(v.bw_e));
    chk($sformatf("v%0d_busy", id),  32'(busy),       32'd1);
    acked  = 1'b0;
    aborts = 0;
    for (int n = 1; n <= 16 && !acked; n++) begin
      nrn_done = (v.dly >= 0) && (n == v.dly + 1);
      if (v.chg && n == 3) begin
        req    = '0;
        base_x = ~v.bx;
        base_w = ~v.bw;
      end
      @(negedge clk);
      if (nrn_abort) aborts++;
      if (|ack) begin
        acked = 1'b1;
        if (sb.size() == 0) begin
          chk($sformatf("v%0d_sb_empty", id), 32'd0, 32'd1);
        end else begin
          e = sb.pop_front();
          chk($sformatf("v%0d_ack", id),       32'(ack),        32'(e.gnt));
          chk($sformatf("v%0d_err", id),       32'(err),        e.err ? 32'(e.gnt) : 32'd0);
          chk($sformatf("v%0d_ack_cycle", id), 32'(n + 1),      32'(e.ack_cyc));
          chk($sformatf("v%0d_abort", id),     32'(nrn_abort),  32'(e.err));
          chk($sformatf("v%0d_gnt_resp", id),  32'(gnt),        32'(e.gnt));
          chk($sformatf("v%0d_bx_resp", id),   32'(nrn_base_x), 32'(e.bx));
          chk($sformatf("v%0d_bw_resp", id),   32'(nrn_base_w), 32'(e.bw));
        end
      end
    end
    nrn_done = 1'b0;
    if (!acked) begin
      chk($sformatf("v%0d_ack_timeout", id), 32'd0, 32'd1);
      if (sb.size() != 0) void'(sb.pop_front());
    end
    chk($sformatf("v%0d_abort_count", id), 32'(aborts), 32'(v.err_e));
    req = '0;
    @(negedge clk);
    chk($sformatf("v%0d_idle_ack", id),  32'(ack),  32'd0);
    chk($sformatf("v%0d_idle_busy", id), 32'(busy), 32'd0);
    chk($sformatf("v%0d_idle_gnt", id),  32'(gnt),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "global timeout");
  end

  initial begin
    rst = 1'b0; req = '0; base_x = '0; base_w = '0; nrn_done = 1'b0;

    tbl[0] = mk(4'b1111, B_X, B_W,  1, 1'b0, 4'b0001, 0, 8'h11, 8'hA1, 1'b0, 3);
    tbl[1] = mk(4'b1111, B_X, B_W,  2, 1'b0, 4'b0010, 1, 8'h22, 8'hB2, 1'b0, 4);
    tbl[2] = mk(4'b1111, B_X, B_W,  3, 1'b0, 4'b0100, 2, 8'h33, 8'hC3, 1'b0, 5);
    tbl[3] = mk(4'b1111, B_X, B_W,  1, 1'b0, 4'b1000, 3, 8'h44, 8'hD4, 1'b0, 3);
    tbl[4] = mk(4'b1111, B_X, B_W,  2, 1'b0, 4'b0001, 0, 8'h11, 8'hA1, 1'b0, 4);
    tbl[5] = mk(4'b0100, 32'hAA10_BBCC, 32'h1180_2233, 5, 1'b0, 4'b0100, 2, 8'h10, 8'h80, 1'b0, 7);
    tbl[6] = mk(4'b0010, B_X, B_W, -1, 1'b0, 4'b0010, 1, 8'h22, 8'hB2, 1'b1, 10);
    tbl[7] = mk(4'b0011, B_X, B_W, -1, 1'b0, 4'b0001, 0, 8'h11, 8'hA1, 1'b1, 10);
    tbl[8] = mk(4'b1001, B_X, B_W,  8, 1'b0, 4'b1000, 3, 8'h44, 8'hD4, 1'b0, 10);
    tbl[9] = mk(4'b0100, B_X, B_W,  4, 1'b1, 4'b0100, 2, 8'h33, 8'hC3, 1'b0, 6);

    repeat (2) @(negedge clk);
    chk_zero("in_reset");
    rst = 1'b1;
    @(negedge clk);
    chk_zero("post_reset");

    for (int i = 0; i < 10; i++) run_vec(tbl[i], i);

    // Completion pulses while idle must not start or finish anything.
    nrn_done = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("spur%0d_busy", i), 32'(busy),   32'd0);
      chk($sformatf("spur%0d_st", i),   32'(nrn_st), 32'd0);
      chk($sformatf("spur%0d_ack", i),  32'(ack),    32'd0);
    end
    nrn_done = 1'b0;
    run_vec(mk(4'b1101, B_X, B_W, 2, 1'b0, 4'b1000, 3, 8'h44, 8'hD4, 1'b0, 4), 10);

    // Asynchronous reset in the middle of RUN.
    req = 4'b0001; base_x = B_X; base_w = B_W;
    @(negedge clk);
    chk("arst_start", 32'(nrn_st), 32'd1);
    chk("arst_gnt",   32'(gnt),    32'h1);
    repeat (2) @(negedge clk);
    chk("arst_busy_run", 32'(busy), 32'd1);
    #2 rst = 1'b0;
    #1 chk_zero("arst_now");
    @(negedge clk);
    chk_zero("arst_held");
    rst = 1'b1;
    run_vec(mk(4'b1000, B_X, B_W, 1, 1'b0, 4'b1000, 3, 8'h44, 8'hD4, 1'b0, 3), 11);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
